gate_truth_checker: RTL

//  Sequential stimulus/response engine for combinational gates under test
//  (Nand and derived gates). On start, sweeps every input vector into the

---
 rtl/gate_truth_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives every input vector into a combinational gate,
// waits SETTLE cycles, samples the gate output and compares it with a
// truth table latched at start. Reports pass, mismatch count and first
// failing vector.
// Optional feature macro: GATE_CHECK_STOP_ON_FAIL_EN (end sweep on first mismatch).
module gate_truth_checker #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expect_tt,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          fail_count,
  output logic [N_IN-1:0]        first_fail_vec
);

  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned FW = N_IN + 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t            state_q, state_n;
  logic [NV-1:0]     tt_q, tt_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [N_IN-1:0]   dut_in_n;
  logic              busy_n, done_n, pass_n;
  logic [N_IN:0]     fail_n;
  logic [N_IN-1:0]   first_n;
  logic              sample, miss, last, stop;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      tt_q           <= '0;
      cnt_q          <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else begin
      state_q        <= state_n;
      tt_q           <= tt_n;
      cnt_q          <= cnt_n;
      dut_in         <= dut_in_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      fail_count     <= fail_n;
      first_fail_vec <= first_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    tt_n     = tt_q;
    cnt_n    = cnt_q;
    dut_in_n = dut_in;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;
    fail_n   = fail_count;
    first_n  = first_fail_vec;

    sample = (cnt_q == CW'(SETTLE));
    miss   = sample && (dut_out != tt_q[dut_in]);
    last   = (dut_in == N_IN'(NV - 1));
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    stop   = last || miss;
`else
    stop   = last;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          tt_n     = expect_tt;
          fail_n   = '0;
          first_n  = '0;
          pass_n   = 1'b0;
          dut_in_n = '0;
          cnt_n    = '0;
          busy_n   = 1'b1;
          state_n  = DRIVE;
        end
      end
      DRIVE: begin
        if (sample) begin
          if (miss) begin
            fail_n = fail_count + FW'(1);
            if (fail_count == '0) first_n = dut_in;
          end
          if (stop) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (fail_n == '0);
          end else begin
            dut_in_n = dut_in + N_IN'(1);
            cnt_n    = '0;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
